rom_bus_arbiter: RTL and testbench
==================================

// Module: rom_bus_arbiter
// PURPOSE
//  Shares the instruction memory's data/write port between two masters: M0 = core LSU, M1 = boot
//  loader/debug writer. Registered request/grant FSM with burst cap and registered read return.
//  Sits between the masters and the memory's r_addr2/w_* port; fetch port r_addr1 is not touched.
// PARAMETERS
//  MAX_BURST  8  max consecutive granted beats per owner while the other master waits (>=1)
//  CNT_W      3  burst counter width, = clog2(MAX_BURST)
// PORTS
//  clk            in   1    system clock, rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  mX_req_i       in   1    (X=0,1) request; addr/we/wdata/sel held stable until gnt
//  mX_we_i        in   1    1 = write, 0 = read
//  mX_addr_i      in   `MemAddrBus  byte address, passed unchanged
//  mX_wdata_i     in   `WordBus     write data
//  mX_sel_i       in   4    byte lanes [3]=31:24 .. [0]=7:0
//  mX_gnt_o       out  1    beat accepted at this edge
//  mX_rvalid_o    out  1    read data valid (cycle after read beat)
//  mX_rdata_o     out  `WordBus     read data, held until next read beat of that master
//  mem_raddr_o    out  `MemAddrBus  to memory r_addr2_i
//  mem_rdata_i    in   `WordBus     from memory r_data2_o (combinational)
//  mem_wen_o/mem_waddr_o/mem_wdata_o/mem_wsel_o  out  1/`MemAddrBus/`WordBus/4  to memory w_*
//  arb_busy_o     out  1    state != IDLE
//  arb_owner_o    out  1    current/last owner index
// BEHAVIOUR
//  Reset (async): state IDLE, all gnt/rvalid 0, rdata 0, burst cnt 0, owner 0, rr pointer 0,
//   mem_wen_o 0, mem addr/data/sel 0. Reset mid-beat aborts it; no write reaches memory.
//  States: IDLE, OWN0, OWN1. IDLE: mX_req_i sampled; next edge enters OWNx (1-cycle grant latency).
//  In OWNx: mX_gnt_o = mX_req_i (combinational); memory ports driven from owner's inputs;
//   mem_wen_o = gnt & we. Other master's gnt 0. In IDLE memory outputs are 0.
//  Each gnt cycle = one beat; write commits at that edge, read captures mem_rdata_i into
//   mX_rdata_o at that edge, mX_rvalid_o = 1 next cycle for one cycle (back-to-back reads keep it high).
//  Burst cnt increments per beat; reset to 0 on every ownership change.
//  Transition at edge, from OWNx: owner req low -> OWNy if y req else IDLE;
//   beat with cnt==MAX_BURST-1 -> OWNy if y req (no bubble), else stay, cnt 0; otherwise stay.
//  Simultaneous req in IDLE: resolved per CONFIGURATION. sel==0 write: mem_wen_o still 1, no byte changes.
//  Address low bits and alignment not checked; passed through.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: simultaneous-IDLE tie goes to master != last owner (pointer flips on
//   each ownership change). Undefined: M1 (loader) always wins ties; burst cap still preempts M1 for M0.
// STRUCTURE
//  Widths/ZeroWord from `buceros_header.v`; add `ArbIdle/`ArbOwn0/`ArbOwn1 (2-bit) state defines there.
//  Sub-module arb_pick (combinational tie-break + rr pointer input); rest inline.
// TESTING
//  M0 write 0xDEADBEEF @0x10 sel 4'hF from IDLE -> gnt at cycle 2, mem word 4 = 0xDEADBEEF.
//  M0 read @0x10 -> m0_rvalid_o high 1 cycle after gnt, m0_rdata_o = 0xDEADBEEF; M1 rvalid stays 0.
//  M1 write 0x000000AA sel 4'b0001 over 0xDEADBEEF -> word = 0xDEADBEAA.
//  Both req continuously, MAX_BURST=8 -> gnt alternates 8 beats M0/8 beats M1, no idle cycle between.
//  Both req in IDLE: RR build -> owner alternates per reacquire; fixed build -> M1 first every time.
//  rst_n low mid-write burst -> gnt/wen 0 immediately, state IDLE, memory unchanged by that beat.

Source files
------------

// File: rtl/rom_bus_arbiter_pkg.sv
// Shared widths and arbiter state encoding for rom_bus_arbiter.
// Optional build macro used by the arbiter: ARB_ROUND_ROBIN_EN.
package rom_bus_arbiter_pkg;

  localparam int unsigned MemAddrW = 32;
  localparam int unsigned WordW    = 32;
  localparam logic [WordW-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbOwn0 = 2'd1,
    ArbOwn1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e own_state(input logic idx);
    return idx ? ArbOwn1 : ArbOwn0;
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_arb_pick.sv
// Tie-break for simultaneous requests seen while the arbiter is idle.
// RoundRobin=1 hands a tie to the master that did not own the bus last; otherwise M1 wins.
module rom_bus_arbiter_arb_pick #(
  parameter bit RoundRobin = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic pick
);

  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = RoundRobin ? ~rr_last : 1'b1;
    end
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Two-master arbiter for the instruction memory data/write port, with burst cap.
// Define ARB_ROUND_ROBIN_EN for round-robin idle tie-break; default build favours M1 (loader).
module rom_bus_arbiter
  import rom_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [MemAddrW-1:0] m0_addr_i,
  input  logic [WordW-1:0]    m0_wdata_i,
  input  logic [3:0]          m0_sel_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [WordW-1:0]    m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [MemAddrW-1:0] m1_addr_i,
  input  logic [WordW-1:0]    m1_wdata_i,
  input  logic [3:0]          m1_sel_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [WordW-1:0]    m1_rdata_o,
  output logic [MemAddrW-1:0] mem_raddr_o,
  input  logic [WordW-1:0]    mem_rdata_i,
  output logic                mem_wen_o,
  output logic [MemAddrW-1:0] mem_waddr_o,
  output logic [WordW-1:0]    mem_wdata_o,
  output logic [3:0]          mem_wsel_o,
  output logic                arb_busy_o,
  output logic                arb_owner_o
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  arb_state_e       state_q;
  logic             owner_q;
  logic             rr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             m0_rvalid_q, m1_rvalid_q;
  logic [WordW-1:0] m0_rdata_q, m1_rdata_q;

  logic                busy, cur;
  logic                o_req, o_we, y_req;
  logic [MemAddrW-1:0] o_addr;
  logic [WordW-1:0]    o_wdata;
  logic [3:0]          o_sel;
  logic                cap, pick;
  logic                m0_rd_beat, m1_rd_beat;

  rom_bus_arbiter_arb_pick #(
    .RoundRobin(RrEn)
  ) u_arb_pick (
    .req0   (m0_req_i),
    .req1   (m1_req_i),
    .rr_last(rr_q),
    .pick   (pick)
  );

  // Mux the current owner's request onto a common set of signals.
  always_comb begin
    busy    = (state_q != ArbIdle);
    cur     = (state_q == ArbOwn1);
    o_req   = cur ? m1_req_i   : m0_req_i;
    o_we    = cur ? m1_we_i    : m0_we_i;
    o_addr  = cur ? m1_addr_i  : m0_addr_i;
    o_wdata = cur ? m1_wdata_i : m0_wdata_i;
    o_sel   = cur ? m1_sel_i   : m0_sel_i;
    y_req   = cur ? m0_req_i   : m1_req_i;
    cap     = (cnt_q == CNT_W'(MAX_BURST - 1));
  end

  always_comb begin
    m0_gnt_o    = (state_q == ArbOwn0) && m0_req_i;
    m1_gnt_o    = (state_q == ArbOwn1) && m1_req_i;
    m0_rd_beat  = m0_gnt_o && !m0_we_i;
    m1_rd_beat  = m1_gnt_o && !m1_we_i;
    mem_raddr_o = busy ? o_addr  : '0;
    mem_waddr_o = busy ? o_addr  : '0;
    mem_wdata_o = busy ? o_wdata : ZeroWord;
    mem_wsel_o  = busy ? o_sel   : 4'h0;
    mem_wen_o   = (m0_gnt_o || m1_gnt_o) && o_we;
    arb_busy_o  = busy;
    arb_owner_o = owner_q;
    m0_rvalid_o = m0_rvalid_q;
    m1_rvalid_o = m1_rvalid_q;
    m0_rdata_o  = m0_rdata_q;
    m1_rdata_o  = m1_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ArbIdle;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= ZeroWord;
      m1_rdata_q  <= ZeroWord;
    end else begin
      m0_rvalid_q <= m0_rd_beat;
      m1_rvalid_q <= m1_rd_beat;
      if (m0_rd_beat) m0_rdata_q <= mem_rdata_i;
      if (m1_rd_beat) m1_rdata_q <= mem_rdata_i;

      case (state_q)
        ArbIdle: begin
          if (m0_req_i || m1_req_i) begin
            state_q <= own_state(pick);
            owner_q <= pick;
            rr_q    <= pick;
            cnt_q   <= '0;
          end
        end
        ArbOwn0, ArbOwn1: begin
          if (!o_req) begin
            cnt_q <= '0;
            if (y_req) begin
              state_q <= own_state(~cur);
              owner_q <= ~cur;
              rr_q    <= ~cur;
            end else begin
              state_q <= ArbIdle;
            end
          end else if (cap) begin
            // Burst cap reached: hand over without a bubble if the other side waits.
            cnt_q <= '0;
            if (y_req) begin
              state_q <= own_state(~cur);
              owner_q <= ~cur;
              rr_q    <= ~cur;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: directed pins plus randomized traffic against a
// transaction-level model of ownership, burst cap and memory contents.
module tb_rom_bus_arbiter;

  localparam int MaxBurst = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_clr;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel   [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_wen, arb_busy, arb_owner;
  logic [3:0]  mem_wsel;

  logic [31:0] env_mem [16];

  int checks = 0;
  int failures = 0;

  rom_bus_arbiter #(
    .MAX_BURST(MaxBurst),
    .CNT_W    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req_i   (req[0]),
    .m0_we_i    (we[0]),
    .m0_addr_i  (addr[0]),
    .m0_wdata_i (wdata[0]),
    .m0_sel_i   (sel[0]),
    .m0_gnt_o   (m0_gnt),
    .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o (m0_rdata),
    .m1_req_i   (req[1]),
    .m1_we_i    (we[1]),
    .m1_addr_i  (addr[1]),
    .m1_wdata_i (wdata[1]),
    .m1_sel_i   (sel[1]),
    .m1_gnt_o   (m1_gnt),
    .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o (m1_rdata),
    .mem_raddr_o(mem_raddr),
    .mem_rdata_i(mem_rdata),
    .mem_wen_o  (mem_wen),
    .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata),
    .mem_wsel_o (mem_wsel),
    .arb_busy_o (arb_busy),
    .arb_owner_o(arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT: combinational read, byte-lane write at the edge.
  assign mem_rdata = env_mem[mem_raddr[5:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= '0;
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wsel[b]) env_mem[mem_waddr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_own;      // -1 when nobody holds the bus
  bit          m_last;     // last owner
  int          m_run;      // beats completed in the current tenure
  logic [31:0] m_mem [16];
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  bit          mg [2];

  function automatic void model_reset();
    m_own = -1; m_last = 1'b0; m_run = 0;
    for (int x = 0; x < 2; x++) begin m_rv[x] = 1'b0; m_rd[x] = '0; mg[x] = 1'b0; end
  endfunction

  function automatic void take(input int w);
    m_own = w; m_last = w[0]; m_run = 0;
  endfunction

  function automatic void model_step();
    for (int x = 0; x < 2; x++) begin
      bit g;
      g = (m_own == x) && req[x];
      m_rv[x] = g && !we[x];
      if (g && !we[x]) m_rd[x] = m_mem[addr[x][5:2]];
      if (g && we[x])
        for (int b = 0; b < 4; b++)
          if (sel[x][b]) m_mem[addr[x][5:2]][b*8 +: 8] = wdata[x][b*8 +: 8];
    end
    if (m_own < 0) begin
      if (req[0] && req[1]) take(Rr ? int'(!m_last) : 1);
      else if (req[0]) take(0);
      else if (req[1]) take(1);
    end else begin
      int x, y;
      x = m_own; y = 1 - x;
      if (!req[x]) begin
        if (req[y]) take(y); else m_own = -1;
      end else begin
        m_run++;
        if (m_run == MaxBurst) begin
          if (req[y]) take(y); else m_run = 0;
        end
      end
    end
  endfunction

  task automatic compare();
    bit          ewen;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    for (int x = 0; x < 2; x++) mg[x] = (m_own == x) && req[x];
    ewen = (m_own >= 0) && mg[m_own[0]] && we[m_own[0]];
    ea = (m_own >= 0) ? addr[m_own[0]]  : 32'h0;
    ed = (m_own >= 0) ? wdata[m_own[0]] : 32'h0;
    es = (m_own >= 0) ? sel[m_own[0]]   : 4'h0;
    chk("gnt0", {31'h0, m0_gnt}, {31'h0, mg[0]});
    chk("gnt1", {31'h0, m1_gnt}, {31'h0, mg[1]});
    chk("busy", {31'h0, arb_busy}, {31'h0, m_own >= 0});
    chk("owner", {31'h0, arb_owner}, {31'h0, m_last});
    chk("wen", {31'h0, mem_wen}, {31'h0, ewen});
    chk("rvalid0", {31'h0, m0_rvalid}, {31'h0, m_rv[0]});
    chk("rvalid1", {31'h0, m1_rvalid}, {31'h0, m_rv[1]});
    chk("rdata0", m0_rdata, m_rd[0]);
    chk("rdata1", m1_rdata, m_rd[1]);
    chk("raddr", mem_raddr, ea);
    chk("waddr", mem_waddr, ea);
    chk("wdata", mem_wdata, ed);
    chk("wsel", {28'h0, mem_wsel}, {28'h0, es});
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare();
      @(posedge clk);
      if (mem_clr) for (int i = 0; i < 16; i++) m_mem[i] = '0;
      if (!rst_n) model_reset(); else model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int x, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req[x] = 1'b1; we[x] = w; addr[x] = a; wdata[x] = d; sel[x] = s;
  endtask

  task automatic wait_gnt(input int x, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((x == 0) ? m0_gnt : m1_gnt) break;
      lat++;
    end
  endtask

  task automatic new_txn(input int x);
    set_req(x, 1'($urandom_range(1)), 32'($urandom_range(255)), $urandom,
            4'($urandom_range(15)));
  endtask

  initial begin
    int lat;
    bit first, exp_last, win;
    int pcont;
    int pc_tab [4];
    pc_tab[0] = 50; pc_tab[1] = 90; pc_tab[2] = 100; pc_tab[3] = 70;
    for (int x = 0; x < 2; x++) begin
      req[x] = 1'b0; we[x] = 1'b0; addr[x] = '0; wdata[x] = '0; sel[x] = '0;
    end
    rst_n = 1'b0; mem_clr = 1'b1;
    repeat (3) tick();

    @(negedge clk);
    chk("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rst_busy_owner", {30'h0, arb_busy, arb_owner}, 32'h0);
    chk("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_wen", {31'h0, mem_wen}, 32'h0);
    tick();
    rst_n = 1'b1; mem_clr = 1'b0;
    tick();

    // M0 full-word write from idle: one cycle of grant latency.
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_gnt(0, lat);
    chk("w0_latency", lat, 1);
    tick();
    req[0] = 1'b0;
    chk("w0_mem", env_mem[4], 32'hDEAD_BEEF);

    // M0 read back while still owner.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    wait_gnt(0, lat);
    chk("r0_latency", lat, 0);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("r0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("r0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("r0_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    tick();
    @(negedge clk);
    chk("r0_rvalid_drop", {31'h0, m0_rvalid}, 32'h0);
    tick();

    // M1 single-lane write.
    set_req(1, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
    wait_gnt(1, lat);
    chk("w1_latency", lat, 1);
    tick();
    req[1] = 1'b0;
    chk("w1_mem", env_mem[4], 32'hDEAD_BEAA);
    repeat (3) tick();

    // Both requesting continuously: 8-beat tenures alternate with no idle cycle.
    first = Rr ? 1'b0 : 1'b1;
    set_req(0, 1'b0, 32'h20, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h24, 32'h0, 4'hF);
    @(negedge clk);
    chk("burst_idle", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    for (int k = 0; k < 32; k++) begin
      bit o;
      tick();
      @(negedge clk);
      o = first ^ 1'((k / 8) & 1);
      chk("burst_pattern", {30'h0, m1_gnt, m0_gnt}, o ? 32'h2 : 32'h1);
    end
    tick();
    req[0] = 1'b0; req[1] = 1'b0;
    exp_last = first;
    repeat (2) tick();

    // Simultaneous requests from idle, repeated.
    for (int r = 0; r < 4; r++) begin
      set_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h4, 32'h0, 4'hF);
      @(negedge clk);
      tick();
      @(negedge clk);
      win = Rr ? !exp_last : 1'b1;
      chk("tie_winner", {30'h0, m1_gnt, m0_gnt}, win ? 32'h2 : 32'h1);
      tick();
      req[0] = 1'b0; req[1] = 1'b0;
      exp_last = win;
      repeat (2) tick();
    end

    // Reset in the middle of a write burst: second beat must not reach memory.
    set_req(0, 1'b1, 32'h20, 32'h1111_1111, 4'hF);
    wait_gnt(0, lat);
    tick();
    wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("rst_mid_wen", {31'h0, mem_wen}, 32'h0);
    chk("rst_mid_busy", {31'h0, arb_busy}, 32'h0);
    req[0] = 1'b0;
    tick();
    chk("rst_mid_mem", env_mem[8], 32'h1111_1111);
    rst_n = 1'b1;
    repeat (2) tick();

    // Randomized traffic, checked every cycle by the model.
    for (int seg = 0; seg < 8; seg++) begin
      pcont = pc_tab[seg % 4];
      for (int c = 0; c < 200; c++) begin
        tick();
        for (int x = 0; x < 2; x++) begin
          if (req[x] && mg[x]) begin
            if ($urandom_range(99) < pcont) new_txn(x);
            else req[x] = 1'b0;
          end else if (!req[x] && $urandom_range(99) < 40) begin
            new_txn(x);
          end
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
